// File: rtl/multicycle_ctrl_if.sv
// Handshake/control bundle between the multicycle RV32I controller (master)
// and its datapath plus shared memory (slave).
interface multicycle_ctrl_if;
    logic [31:0] Instr;
    logic        Zero;
    logic        CarryOut;
    logic        Overflow;
    logic        Sign;
    logic        MemReady;
    logic        PCWrite;
    logic        AdrSrc;
    logic        MemWrite;
    logic        IRWrite;
    logic        RegWrite;
    logic [1:0]  ResultSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [2:0]  ImmSrc;
    logic [3:0]  ALUControl;
    logic        Halt;
    logic        Retire;

    modport master (
        input  Instr, Zero, CarryOut, Overflow, Sign, MemReady,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Halt, Retire
    );

    modport slave (
        output Instr, Zero, CarryOut, Overflow, Sign, MemReady,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Halt, Retire
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback,
// waits on MemReady for memory accesses and parks in TRAP on illegal encodings.
module multicycle_ctrl #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic              clk,
    input  logic              rst_n,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
        ALUWB, BRANCH, JAL, JALR_A, JALR_J, LUI, AUIPC, TRAP
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] F7_ALT   = 7'b0100000;

    localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010,
                           ALU_OR  = 4'b0011, ALU_XOR = 4'b0100, ALU_SLT = 4'b0101,
                           ALU_SLTU = 4'b0110, ALU_SLL = 4'b0111, ALU_SRL = 4'b1000,
                           ALU_SRA = 4'b1001, ALU_PASSB = 4'b1010;

    state_t      state;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        r_legal, i_legal, br_illegal;

    assign opcode = bus.Instr[6:0];
    assign funct3 = bus.Instr[14:12];
    assign funct7 = bus.Instr[31:25];

    // SUB only exists in the register form; addi with imm[10]=1 is still ADD
    function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic alt, input logic is_r);
        case (f3)
            3'b000:  alu_dec = (is_r && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_dec = ALU_SLL;
            3'b010:  alu_dec = ALU_SLT;
            3'b011:  alu_dec = ALU_SLTU;
            3'b100:  alu_dec = ALU_XOR;
            3'b101:  alu_dec = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_dec = ALU_OR;
            default: alu_dec = ALU_AND;
        endcase
    endfunction

    function automatic logic br_taken(input logic [2:0] f3, input logic z, input logic c,
                                      input logic v, input logic s);
        case (f3)
            3'b000:  br_taken = z;
            3'b001:  br_taken = !z;
            3'b100:  br_taken = s ^ v;
            3'b101:  br_taken = !(s ^ v);
            3'b110:  br_taken = !c;
            3'b111:  br_taken = c;
            default: br_taken = 1'b0;
        endcase
    endfunction

    assign r_legal = (funct7 == 7'd0) ||
                     ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
    assign i_legal = (funct3 == 3'b001) ? (funct7 == 7'd0) :
                     (funct3 == 3'b101) ? ((funct7 == 7'd0) || (funct7 == F7_ALT)) : 1'b1;
    assign br_illegal = (funct3 == 3'b010) || (funct3 == 3'b011);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= state_t'(RESET_STATE);
        end else begin
            case (state)
                FETCH:    if (bus.MemReady) state <= DECODE;
                DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: state <= MEMADR;
                        OP_R:         state <= EXECR;
                        OP_I:         state <= EXECI;
                        OP_BR:        state <= BRANCH;
                        OP_JAL:       state <= JAL;
                        OP_JALR:      state <= JALR_A;
                        OP_LUI:       state <= LUI;
                        OP_AUIPC:     state <= AUIPC;
                        default:      state <= TRAP;
                    endcase
                end
                MEMADR: begin
                    if (funct3 != 3'b010)    state <= TRAP;
                    else if (opcode == OP_LW) state <= MEMREAD;
                    else                      state <= MEMWRITE;
                end
                MEMREAD:  if (bus.MemReady) state <= MEMWB;
                MEMWB:    state <= FETCH;
                MEMWRITE: if (bus.MemReady) state <= FETCH;
                EXECR:    state <= r_legal ? ALUWB : TRAP;
                EXECI:    state <= i_legal ? ALUWB : TRAP;
                ALUWB:    state <= FETCH;
                BRANCH:   state <= br_illegal ? TRAP : FETCH;
                JAL:      state <= ALUWB;
                JALR_A:   state <= (funct3 != 3'b000) ? TRAP : JALR_J;
                JALR_J:   state <= ALUWB;
                LUI:      state <= ALUWB;
                AUIPC:    state <= ALUWB;
                TRAP:     state <= TRAP;
                default:  state <= TRAP;
            endcase
        end
    end

    logic       pcw, adr, mw, irw, rw, ret;
    logic [1:0] res, sa, sb;
    logic [3:0] aluc;

    always_comb begin
        pcw = 1'b0; adr = 1'b0; mw = 1'b0; irw = 1'b0; rw = 1'b0; ret = 1'b0;
        res = 2'b00; sa = 2'b00; sb = 2'b00; aluc = ALU_ADD;
        case (state)
            FETCH: begin
                sb  = 2'b10;
                res = 2'b10;
                irw = bus.MemReady;
                pcw = bus.MemReady;
            end
            DECODE:   begin sa = 2'b01; sb = 2'b01; end
            MEMADR:   begin sa = 2'b10; sb = 2'b01; end
            MEMREAD:  adr = 1'b1;
            MEMWB:    begin res = 2'b01; rw = 1'b1; ret = 1'b1; end
            MEMWRITE: begin adr = 1'b1; mw = 1'b1; ret = bus.MemReady; end
            EXECR:    begin sa = 2'b10; aluc = alu_dec(funct3, funct7[5], 1'b1); end
            EXECI:    begin sa = 2'b10; sb = 2'b01; aluc = alu_dec(funct3, funct7[5], 1'b0); end
            ALUWB:    begin rw = 1'b1; ret = 1'b1; end
            BRANCH: begin
                sa   = 2'b10;
                aluc = ALU_SUB;
                pcw  = br_taken(funct3, bus.Zero, bus.CarryOut, bus.Overflow, bus.Sign);
                ret  = !br_illegal;
            end
            JAL, JALR_J: begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
            JALR_A:   begin sa = 2'b10; sb = 2'b01; end
            LUI:      begin sb = 2'b01; aluc = ALU_PASSB; end
            AUIPC:    begin sa = 2'b01; sb = 2'b01; end
            default:  ;
        endcase
    end

    always_comb begin
        case (opcode)
            OP_LW, OP_JALR, OP_I: bus.ImmSrc = 3'b000;
            OP_SW:                bus.ImmSrc = 3'b001;
            OP_BR:                bus.ImmSrc = 3'b010;
            OP_JAL:               bus.ImmSrc = 3'b011;
            OP_LUI, OP_AUIPC:     bus.ImmSrc = 3'b100;
            default:              bus.ImmSrc = 3'b000;
        endcase
    end

    // state already sits at FETCH during reset, so gate the enables directly
    assign bus.PCWrite    = pcw & rst_n;
    assign bus.MemWrite   = mw  & rst_n;
    assign bus.IRWrite    = irw & rst_n;
    assign bus.RegWrite   = rw  & rst_n;
    assign bus.Retire     = ret & rst_n;
    assign bus.AdrSrc     = adr;
    assign bus.ResultSrc  = res;
    assign bus.ALUSrcA    = sa;
    assign bus.ALUSrcB    = sb;
    assign bus.ALUControl = aluc;
    assign bus.Halt       = (state == TRAP);
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks instruction classes through the FSM
// and checks the combinational controls each cycle against hand-derived values.
module tb_multicycle_ctrl;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.RESET_STATE(4'd0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_en(input string tag, input logic [4:0] exp);
        chk(tag, {27'd0, bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.Retire},
            {27'd0, exp});
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.Instr = 32'h00500093;
        bus.Zero = 1'b0; bus.CarryOut = 1'b0; bus.Overflow = 1'b0; bus.Sign = 1'b0;
        bus.MemReady = 1'b1;
        #2;
        chk_en("rst_enables", 5'b00000);
        chk("rst_halt", bus.Halt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // addi x1,x0,5
        chk_en("addi_fetch_en", 5'b11000);
        chk("addi_fetch_srcb", bus.ALUSrcB, 2);
        chk("addi_fetch_res", bus.ResultSrc, 2);
        tick();
        chk("addi_dec_srca", bus.ALUSrcA, 1);
        chk("addi_dec_srcb", bus.ALUSrcB, 1);
        chk_en("addi_dec_en", 5'b00000);
        tick();
        chk("addi_exe_srca", bus.ALUSrcA, 2);
        chk("addi_exe_srcb", bus.ALUSrcB, 1);
        chk("addi_exe_alu", bus.ALUControl, 0);
        chk_en("addi_exe_en", 5'b00000);
        tick();
        chk_en("addi_wb_en", 5'b00101);
        chk("addi_wb_res", bus.ResultSrc, 0);
        bus.Instr = 32'h0000A103;
        tick();
        chk_en("addi_back_fetch", 5'b11000);

        // lw x2,0(x1) with 3 wait cycles
        tick();
        chk("lw_dec_imm", bus.ImmSrc, 0);
        tick();
        chk("lw_madr_srca", bus.ALUSrcA, 2);
        chk("lw_madr_srcb", bus.ALUSrcB, 1);
        tick();
        bus.MemReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lw_wait_adr", bus.AdrSrc, 1);
            chk_en("lw_wait_en", 5'b00000);
            tick();
        end
        bus.MemReady = 1'b1;
        #1;
        chk("lw_ready_adr", bus.AdrSrc, 1);
        tick();
        chk("lw_wb_res", bus.ResultSrc, 1);
        chk_en("lw_wb_en", 5'b00101);
        bus.Instr = 32'h0020A023;
        tick();
        chk_en("lw_back_fetch", 5'b11000);

        // sw x2,0(x1) with MemReady delayed 2 cycles
        tick();
        chk("sw_dec_imm", bus.ImmSrc, 1);
        tick();
        chk_en("sw_madr_en", 5'b00000);
        tick();
        bus.MemReady = 1'b0;
        #1;
        chk_en("sw_w1_en", 5'b00010);
        tick();
        chk_en("sw_w2_en", 5'b00010);
        chk("sw_w2_adr", bus.AdrSrc, 1);
        bus.MemReady = 1'b1;
        #1;
        chk_en("sw_w3_en", 5'b00011);
        bus.Instr = 32'h00000063;
        tick();
        chk_en("sw_after_fetch", 5'b11000);

        // beq: taken with Zero
        tick();
        chk("beq_dec_imm", bus.ImmSrc, 2);
        tick();
        bus.Zero = 1'b1;
        #1;
        chk_en("beq_z1_en", 5'b10001);
        chk("beq_alu", bus.ALUControl, 1);
        bus.Zero = 1'b0;
        #1;
        chk_en("beq_z0_en", 5'b00001);
        bus.Instr = 32'h00006063;
        tick();
        chk_en("beq_back_fetch", 5'b11000);

        // bltu: CarryOut=1 means not-less
        tick();
        tick();
        bus.CarryOut = 1'b1;
        #1;
        chk("bltu_c1_pcw", bus.PCWrite, 0);
        bus.CarryOut = 1'b0;
        #1;
        chk("bltu_c0_pcw", bus.PCWrite, 1);
        bus.Instr = 32'h00004063;
        tick();

        // blt: Sign^Overflow
        tick();
        tick();
        bus.Sign = 1'b1; bus.Overflow = 1'b1;
        #1;
        chk("blt_s1v1_pcw", bus.PCWrite, 0);
        bus.Overflow = 1'b0;
        #1;
        chk("blt_s1v0_pcw", bus.PCWrite, 1);
        bus.Sign = 1'b0;
        bus.Instr = 32'h008000EF;
        tick();

        // jal x1,8
        tick();
        chk("jal_dec_imm", bus.ImmSrc, 3);
        tick();
        chk_en("jal_en", 5'b10000);
        chk("jal_res", bus.ResultSrc, 0);
        chk("jal_srca", bus.ALUSrcA, 1);
        chk("jal_srcb", bus.ALUSrcB, 2);
        tick();
        chk_en("jal_wb_en", 5'b00101);
        bus.Instr = 32'h000080E7;
        tick();

        // jalr x1,0(x1)
        tick();
        tick();
        chk_en("jalr_a_en", 5'b00000);
        chk("jalr_a_srca", bus.ALUSrcA, 2);
        tick();
        chk_en("jalr_j_en", 5'b10000);
        tick();
        chk_en("jalr_wb_en", 5'b00101);
        bus.Instr = 32'h123450B7;
        tick();

        // lui
        tick();
        chk("lui_dec_imm", bus.ImmSrc, 4);
        tick();
        chk("lui_alu", bus.ALUControl, 10);
        chk("lui_srcb", bus.ALUSrcB, 1);
        chk("lui_srca", bus.ALUSrcA, 0);
        tick();
        chk_en("lui_wb_en", 5'b00101);
        bus.Instr = 32'h40208133;
        tick();

        // sub x2,x1,x2
        tick();
        tick();
        chk("sub_alu", bus.ALUControl, 1);
        chk("sub_srcb", bus.ALUSrcB, 0);
        tick();
        chk_en("sub_wb_en", 5'b00101);
        bus.Instr = 32'h4030D093;
        tick();

        // srai x1,x1,3
        tick();
        tick();
        chk("srai_alu", bus.ALUControl, 9);
        tick();
        chk_en("srai_wb_en", 5'b00101);
        bus.Instr = 32'h0000007F;
        tick();

        // illegal opcode: parks in TRAP with no writes
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("ill_op_halt", bus.Halt, 1);
            chk_en("ill_op_en", 5'b00000);
            tick();
        end
        rst_n = 1'b0;
        #1;
        chk("ill_op_rst_halt", bus.Halt, 0);
        chk_en("ill_op_rst_en", 5'b00000);
        bus.Instr = 32'h02208133;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_en("ill_op_refetch", 5'b11000);

        // R-type with funct7=0000001
        tick();
        tick();
        chk("ill_r_exec_halt", bus.Halt, 0);
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("ill_r_halt", bus.Halt, 1);
            chk_en("ill_r_en", 5'b00000);
            tick();
        end
        rst_n = 1'b0;
        #1;
        chk("ill_r_rst_halt", bus.Halt, 0);
        bus.Instr = 32'h0020A023;
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // reset in the middle of a store drops MemWrite at once
        tick();
        tick();
        tick();
        bus.MemReady = 1'b0;
        #1;
        chk("midrst_pre_mw", bus.MemWrite, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_mw", bus.MemWrite, 0);
        bus.MemReady = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_en("midrst_fetch", 5'b11000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control unit for the multicycle RV32I datapath. It sequences fetch, decode, execute, memory and writeback states. It drives every datapath select and enable, and decodes ALU operations and branch conditions from Instr and the ALU flags.
- Adds a ready handshake for the shared instruction/data memory. Halts on illegal instructions.

Parameters:
- RESET_STATE, 4'd0, encoding of FETCH loaded on reset. Fixed; exposed for the bench only.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- Instr  input  32  instruction register contents
- Zero, CarryOut, Overflow, Sign  input  1 each  ALU flags, combinational from the current ALU operation
- MemReady  input  1  memory has completed the current access this cycle
- PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  output  1 each  datapath enables and selects
- ResultSrc  output  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  output  2  00 PC, 01 OldPC, 10 A
- ALUSrcB  output  2  00 WriteData, 01 ImmExt, 10 const 4
- ImmSrc  output  3  000 I, 001 S, 010 B, 011 J, 100 U
- ALUControl  output  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA, 1010 PASSB
- Halt  output  1  sticky; core stopped on an illegal instruction
- Retire  output  1  one-cycle pulse on instruction completion

Behaviour:
- Reset and clocking:
  - Reset is asynchronous and active-low (rst_n).
  - On reset the state goes to FETCH and Halt clears.
  - While rst_n is low, PCWrite, MemWrite, IRWrite, RegWrite and Retire are forced to 0.
- Output timing:
  - Outputs are combinational from the state, Instr, the flags and MemReady.
  - ImmSrc is decoded from opcode in every state: lw/jalr/OP-IMM I; sw S; branch B; jal J; lui/auipc U; otherwise 000.
  - Unlisted outputs in a state are 0. ALUControl defaults to ADD.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ADD, ResultSrc=10.
  - IRWrite and PCWrite are asserted only when MemReady=1; the FSM then goes to DECODE.
  - While MemReady=0, stay in FETCH with no writes.
- DECODE: ALUSrcA=01, ALUSrcB=01, ADD, so ALUOut receives the branch/jal target. Next state by opcode:
  - 0000011 lw, 0100011 sw → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR_A
  - 0110111 → LUI
  - 0010111 → AUIPC
  - anything else → TRAP
- MEMADR: ALUSrcA=10, SrcB=01, ADD. funct3≠010 → TRAP. Else lw → MEMREAD, sw → MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Hold until MemReady, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite, Retire → FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite held until and including the MemReady cycle; then Retire → FETCH.
- EXECR: ALUSrcA=10, SrcB=00.
  - funct7=0000000 gives ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND by funct3.
  - funct7=0100000 is legal only for funct3 000 (SUB) and 101 (SRA).
  - Any other funct7 → TRAP. Otherwise → ALUWB.
- EXECI: ALUSrcA=10, SrcB=01, op by funct3.
  - funct3 001 requires funct7=0000000.
  - funct3 101 requires funct7 0000000 (SRL) or 0100000 (SRA); else TRAP. Otherwise → ALUWB.
- ALUWB: ResultSrc=00, RegWrite, Retire → FETCH.
- BRANCH: ALUSrcA=10, SrcB=00, SUB, ResultSrc=00. PCWrite is asserted when the condition holds:
  - beq: Zero
  - bne: !Zero
  - blt: Sign^Overflow
  - bge: !(Sign^Overflow)
  - bltu: !CarryOut
  - bgeu: CarryOut
  - funct3 010/011 → TRAP; otherwise Retire → FETCH.
- JAL: ALUSrcA=01, SrcB=10, ADD, ResultSrc=00, PCWrite → ALUWB. ALUOut now holds OldPC+4.
- JALR_A: funct3≠000 → TRAP. Otherwise ALUSrcA=10, SrcB=01, ADD → JALR_J.
- JALR_J: same controls as JAL → ALUWB. Target bit 0 is not cleared.
- LUI: SrcB=01, PASSB → ALUWB.
- AUIPC: ALUSrcA=01, SrcB=01, ADD → ALUWB.
- TRAP: Halt=1, all enables 0; stays until reset.
- Latency (with MemReady constantly 1):
  - ALU ops, lui, auipc: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - branch: 3 cycles
  - jal: 4 cycles
  - jalr: 5 cycles
- Boundary cases:
  - Reset mid-access drops MemWrite immediately.
  - Retire never coincides with IRWrite.

Test Plan:
- Reset, then MemReady=1 with Instr=0x00500093 (addi x1,x0,5) → FETCH, DECODE, EXECI (SrcB=01, ADD), ALUWB with RegWrite=1 and Retire; back in FETCH on cycle 5.
- lw 0x0000A103 with MemReady=0 for 3 cycles in MEMREAD → AdrSrc=1 held 4 cycles, then MEMWB with ResultSrc=01 and RegWrite for 1 cycle.
- sw 0x0020A023 with MemReady delayed 2 cycles → MemWrite high exactly 3 cycles, no RegWrite.
- Branches:
  - beq with Zero=1 → PCWrite=1 in BRANCH.
  - bltu with CarryOut=1 → PCWrite=0.
  - blt with Sign=1, Overflow=1 → PCWrite=0.
- jal 0x008000EF → PCWrite in JAL with ResultSrc=00, then RegWrite in ALUWB.
- Illegal: opcode 0x0000007F, and R-type funct7=0x01 → Halt=1, no writes for 10 cycles; asserting rst_n low clears Halt and returns to FETCH asynchronously.
